// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, opcodes and state encoding for the fetch unit
package fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(TIMEOUT);

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC selection (sequential, absolute, relative)
module fetch_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc_next
);

    // Pick the next PC; all sums truncate to PC_W so the PC wraps in both directions
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (pc_sel) begin
            if (br_sel) begin
                pc_next = br_target;
            end else begin
                pc_next = pc + br_target;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch controller with PC, timeout and halt handling
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               FETCH_REQ,
    input  logic               PC_WRITE,
    input  logic               PC_SEL,
    input  logic               BR_SEL,
    input  logic [PC_W-1:0]    BR_TARGET,
    output logic               MEM_RD,
    output logic [PC_W-1:0]    MEM_ADDR,
    input  logic               MEM_ACK,
    input  logic [INSTR_W-1:0] MEM_DATA,
    output logic [INSTR_W-1:0] INSTR,
    output logic [3:0]         OPCODE,
    output logic [3:0]         MM,
    output logic [PC_W-1:0]    PC,
    output logic               INSTR_VALID,
    output logic               BUSY,
    output logic               FETCH_ERR,
    output logic               HALTED
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_next;
    logic [INSTR_W-1:0]  instr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q;
    logic                err_q;
    logic                in_idle;
    logic                fetch_done;
    logic                fetch_timeout;

    assign in_idle       = (state_q == ST_IDLE);
    assign fetch_done    = (state_q == ST_WAIT) && MEM_ACK;
    // The last allowed ACK-less cycle is the one where the counter already shows TIMEOUT-1
    assign fetch_timeout = (state_q == ST_WAIT) && !MEM_ACK && (cnt_q == CNT_W'(TIMEOUT - 1));

    fetch_pc_next u_pc_next (
        .pc        (pc_q),
        .pc_sel    (PC_SEL),
        .br_sel    (BR_SEL),
        .br_target (BR_TARGET),
        .pc_next   (pc_next)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HALT is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (FETCH_REQ) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (MEM_ACK) begin
                    state_d = (MEM_DATA[31:28] == OP_HLT) ? ST_HALT : ST_IDLE;
                end else if (fetch_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        MEM_RD = (state_q == ST_WAIT);
        BUSY   = (state_q == ST_WAIT);
        HALTED = (state_q == ST_HALT);
    end

    // PC only moves in IDLE so the address stays stable while a read is outstanding
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= '0;
        end else if (in_idle && PC_WRITE) begin
            pc_q <= pc_next;
        end
    end

    // Instruction capture and one-cycle completion pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= fetch_done;
            if (fetch_done) begin
                instr_q <= MEM_DATA;
            end
        end
    end

    // ACK-less cycle counter and sticky timeout flag, cleared by a fresh request
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && !MEM_ACK && !fetch_timeout) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (in_idle && FETCH_REQ) begin
                err_q <= 1'b0;
            end else if (fetch_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign MEM_ADDR    = pc_q;
    assign PC          = pc_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[31:28];
    assign MM          = instr_q[27:24];
    assign INSTR_VALID = valid_q;
    assign FETCH_ERR   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic [15:0] br_target;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;
    logic        halted;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .CLK         (clk),
        .RST         (rst),
        .FETCH_REQ   (fetch_req),
        .PC_WRITE    (pc_write),
        .PC_SEL      (pc_sel),
        .BR_SEL      (br_sel),
        .BR_TARGET   (br_target),
        .MEM_RD      (mem_rd),
        .MEM_ADDR    (mem_addr),
        .MEM_ACK     (mem_ack),
        .MEM_DATA    (mem_data),
        .INSTR       (instr),
        .OPCODE      (opcode),
        .MM          (mm),
        .PC          (pc),
        .INSTR_VALID (instr_valid),
        .BUSY        (busy),
        .FETCH_ERR   (fetch_err),
        .HALTED      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc_abs(input logic [15:0] target);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1; br_target = target;
        step();
        pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; br_target = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; pc_write = 1'b1; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        step();
        step();
        rst = 1'b0; fetch_req = 1'b0; pc_write = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_basic_fetch();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL basic_mem_rd: got %b expected 1", mem_rd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL basic_addr: got %h expected 0000", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", instr_valid); end
        mem_ack = 1'b1; mem_data = 32'h8123_4567;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr !== 32'h8123_4567) begin errors++; $display("FAIL basic_instr: got %h expected 81234567", instr); end
        checks++; if (opcode !== 4'h8) begin errors++; $display("FAIL basic_opcode: got %h expected 8", opcode); end
        checks++; if (mm !== 4'h1) begin errors++; $display("FAIL basic_mm: got %h expected 1", mm); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", instr_valid); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL basic_rd_drop: got %b expected 0", mem_rd); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h8123_4567) begin errors++; $display("FAIL basic_instr_hold: got %h expected 81234567", instr); end
    endtask

    task automatic test_pc_update();
        set_pc_abs(16'h0010);
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL pc_abs_setup: got %h expected 0010", pc); end
        pc_write = 1'b1; pc_sel = 1'b0;
        step();
        checks++; if (pc !== 16'h0011) begin errors++; $display("FAIL pc_seq: got %h expected 0011", pc); end
        pc_sel = 1'b1; br_sel = 1'b1; br_target = 16'h0200;
        step();
        checks++; if (pc !== 16'h0200) begin errors++; $display("FAIL pc_abs: got %h expected 0200", pc); end
        br_sel = 1'b0; br_target = 16'hFFFE;
        step();
        checks++; if (pc !== 16'h01FE) begin errors++; $display("FAIL pc_rel_neg: got %h expected 01FE", pc); end
        pc_write = 1'b0; pc_sel = 1'b0; br_target = 16'h0;
        step();
        checks++; if (pc !== 16'h01FE) begin errors++; $display("FAIL pc_hold: got %h expected 01FE", pc); end
    endtask

    task automatic test_wrap();
        set_pc_abs(16'h0000);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0; br_target = 16'hFFFF;
        step();
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_rel_back: got %h expected FFFF", pc); end
        br_target = 16'h0003;
        step();
        checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL wrap_rel_fwd: got %h expected 0002", pc); end
        pc_write = 1'b0; pc_sel = 1'b0; br_target = 16'h0;
        set_pc_abs(16'hFFFF);
        // Sequential write together with a fetch request: the read must use the wrapped PC
        pc_write = 1'b1; pc_sel = 1'b0; fetch_req = 1'b1;
        step();
        pc_write = 1'b0; fetch_req = 1'b0;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_seq: got %h expected 0000", pc); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_fetch_addr: got %h expected 0000", mem_addr); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL wrap_fetch_rd: got %b expected 1", mem_rd); end
        mem_ack = 1'b1; mem_data = 32'h1234_5678;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL wrap_instr: got %h expected 12345678", instr); end
    endtask

    task automatic test_timeout();
        int n;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (mem_rd === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_rd_cycles: got %0d expected 16", n); end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", fetch_err); end
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL timeout_instr: got %h expected 12345678", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b expected 0", instr_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        step();
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", fetch_err); end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", fetch_err); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL timeout_refetch: got %b expected 1", mem_rd); end
        // Acknowledge on the 15th ACK-less cycle boundary: still a normal completion
        for (int i = 0; i < 14; i++) step();
        mem_ack = 1'b1; mem_data = 32'h0A0B_0C0D;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr !== 32'h0A0B_0C0D) begin errors++; $display("FAIL late_ack_instr: got %h expected 0A0B0C0D", instr); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL late_ack_err: got %b expected 0", fetch_err); end
    endtask

    task automatic test_ignore_outside();
        int extra;
        mem_ack = 1'b1; mem_data = 32'h7777_7777;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0A0B_0C0D) begin errors++; $display("FAIL idle_ack_instr: got %h expected 0A0B0C0D", instr); end
        set_pc_abs(16'h0123);
        fetch_req = 1'b1;
        step();
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1; br_target = 16'h5555; fetch_req = 1'b1;
        step();
        pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; br_target = 16'h0; fetch_req = 1'b0;
        checks++; if (pc !== 16'h0123) begin errors++; $display("FAIL wait_pc_stable: got %h expected 0123", pc); end
        checks++; if (mem_addr !== 16'h0123) begin errors++; $display("FAIL wait_addr_stable: got %h expected 0123", mem_addr); end
        mem_ack = 1'b1; mem_data = 32'h1111_2222;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr !== 32'h1111_2222) begin errors++; $display("FAIL wait_instr: got %h expected 11112222", instr); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd === 1'b1) extra++;
            step();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL no_queued_fetch: got %0d expected 0", extra); end
        checks++; if (pc !== 16'h0123) begin errors++; $display("FAIL wait_pc_after: got %h expected 0123", pc); end
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        mem_ack = 1'b1; mem_data = 32'h2000_0001;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        fetch_req = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        step();
        fetch_req = 1'b0; pc_write = 1'b0;
        checks++; if (mem_addr !== 16'h0124) begin errors++; $display("FAIL b2b_addr: got %h expected 0124", mem_addr); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL b2b_rd: got %b expected 1", mem_rd); end
        mem_ack = 1'b1; mem_data = 32'h3000_0002;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (instr !== 32'h3000_0002) begin errors++; $display("FAIL b2b_instr: got %h expected 30000002", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", instr_valid); end
    endtask

    task automatic test_halt();
        int rd_seen;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        mem_ack = 1'b1; mem_data = 32'hF000_0000;
        step();
        mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (instr !== 32'hF000_0000) begin errors++; $display("FAIL halt_instr: got %h expected F0000000", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL halt_valid: got %b expected 1", instr_valid); end
        fetch_req = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_rd === 1'b1) rd_seen++;
        end
        fetch_req = 1'b0; pc_write = 1'b0;
        checks++; if (rd_seen !== 0) begin errors++; $display("FAIL halt_no_rd: got %0d expected 0", rd_seen); end
        checks++; if (pc !== 16'h0124) begin errors++; $display("FAIL halt_pc: got %h expected 0124", pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_stays: got %b expected 1", halted); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b expected 0", halted); end
        set_pc_abs(16'h0042);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        rst = 1'b1; mem_ack = 1'b1; mem_data = 32'h3333_4444;
        step();
        rst = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL midrst_rd: got %b expected 0", mem_rd); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL midrst_pc: got %h expected 0000", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL midrst_instr: got %h expected 00000000", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", instr_valid); end
    endtask

    initial begin
        rst = 1'b0; fetch_req = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
        br_target = 16'h0; mem_ack = 1'b0; mem_data = 32'h0;
        test_reset();
        test_basic_fetch();
        test_pc_update();
        test_wrap();
        test_timeout();
        test_ignore_outside();
        test_back_to_back();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
